// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one add/multiply datapath among NUM_REQ requesters.
// One operation in flight; the result is held in RESP until the consumer accepts it.
module alu_share_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned MUL_LAT = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ-1:0]          req_op,
  input  logic [NUM_REQ*DATA_W-1:0]   req_a,
  input  logic [NUM_REQ*DATA_W-1:0]   req_b,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]  rsp_id,
  output logic [2*DATA_W-1:0]         rsp_data,
  output logic                        busy,
  output logic [7:0]                  grant_count
);

  localparam int unsigned IdW  = $clog2(NUM_REQ);
  localparam int unsigned CntW = $clog2(MUL_LAT + 1);
  localparam int unsigned ResW = 2 * DATA_W;

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e              state_q;
  logic [IdW-1:0]      rr_ptr_q;
  logic [CntW-1:0]     exec_cnt_q;
  logic                op_q;
  logic [DATA_W-1:0]   a_q, b_q;
  logic [IdW-1:0]      id_q;
  logic [IdW-1:0]      rsp_id_q;
  logic [ResW-1:0]     rsp_data_q;
  logic [7:0]          grant_count_q;

  logic                grant_valid;
  logic [IdW-1:0]      grant_idx;
  logic                handshake;
  logic [ResW-1:0]     result;

  // First valid requester at or after rr_ptr_q, wrapping; iterate backwards so nearest wins.
  always_comb begin
    int c;
    c           = 0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
      c = int'(rr_ptr_q) + k;
      if (c >= int'(NUM_REQ)) c = c - int'(NUM_REQ);
      if (req_valid[c[IdW-1:0]]) begin
        grant_valid = 1'b1;
        grant_idx   = c[IdW-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (!rst && state_q == StIdle && grant_valid) begin
      req_ready = NUM_REQ'(1) << grant_idx;
    end
  end

  assign handshake = |(req_valid & req_ready);

  always_comb begin
    logic [ResW-1:0] a_ext, b_ext;
    a_ext  = ResW'(a_q);
    b_ext  = ResW'(b_q);
    result = op_q ? (a_ext * b_ext) : (a_ext + b_ext);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      rr_ptr_q      <= '0;
      exec_cnt_q    <= '0;
      op_q          <= 1'b0;
      a_q           <= '0;
      b_q           <= '0;
      id_q          <= '0;
      rsp_id_q      <= '0;
      rsp_data_q    <= '0;
      grant_count_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (handshake) begin
            op_q          <= req_op[grant_idx];
            a_q           <= req_a[grant_idx*DATA_W +: DATA_W];
            b_q           <= req_b[grant_idx*DATA_W +: DATA_W];
            id_q          <= grant_idx;
            rr_ptr_q      <= (grant_idx == IdW'(NUM_REQ - 1)) ? '0 : grant_idx + IdW'(1);
            grant_count_q <= grant_count_q + 8'd1;
            exec_cnt_q    <= req_op[grant_idx] ? CntW'(MUL_LAT) : CntW'(1);
            state_q       <= StExec;
          end
        end
        StExec: begin
          exec_cnt_q <= exec_cnt_q - CntW'(1);
          if (exec_cnt_q == CntW'(1)) begin
            rsp_data_q <= result;
            rsp_id_q   <= id_q;
            state_q    <= StResp;
          end
        end
        StResp: begin
          if (rsp_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign rsp_valid   = (state_q == StResp);
  assign busy        = (state_q != StIdle);
  assign rsp_id      = rsp_id_q;
  assign rsp_data    = rsp_data_q;
  assign grant_count = grant_count_q;

endmodule
